// File: rtl/rpi_pixel_packer_if.sv
// SRAM byte-write channel from the pixel packer: address/data qualified by valid, accepted by ready.
interface rpi_pixel_packer_if #(
   parameter int ADDR_W = 17
);
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_valid;
   logic              wr_ready;

   modport master (output wr_addr, wr_data, wr_valid, input wr_ready);
   modport slave  (input wr_addr, wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/rpi_pixel_packer.sv
// Packs 1-bit RPi pixels (first pixel in bit 7) into frame-relative SRAM bytes; wr_valid rises ~4 FPGA_clk after the 8th rpi_clk edge.
// One byte of output buffering: a byte completing while the previous one is still unaccepted is dropped and overflow sticks.
module rpi_pixel_packer #(
   parameter int ADDR_W    = 17,
   parameter int MAX_BYTES = 100000
) (
   input  logic               FPGA_clk,
   input  logic               rst,
   input  logic               rpi_clk,
   input  logic               rpi_h_sync,
   input  logic               rpi_v_sync,
   input  logic               rpi_color,
   input  logic               rec,
   rpi_pixel_packer_if.master wr,
   output logic               frame_done,
   output logic               overflow,
   output logic               full
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_CAPTURE,
      S_FULL,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [1:0] clk_sync, hs_sync, vs_sync, col_sync, rec_sync;
   logic       clk_d, vs_d;
   logic       pix_stb, vs_rise, vs_fall, hs_s, vs_s, col_s, rec_s;
   logic [7:0] shift_dat, new_byte;
   logic [2:0] pix_cnt;
   logic       accept, byte_done, hshake, last_hs, load, drop, frame_start, fd_nxt;

   always_ff @(posedge FPGA_clk) begin
      if (rst) begin
         clk_sync <= '0;
         hs_sync  <= '0;
         vs_sync  <= '0;
         col_sync <= '0;
         rec_sync <= '0;
         clk_d    <= 1'b0;
         vs_d     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], rpi_clk};
         hs_sync  <= {hs_sync[0],  rpi_h_sync};
         vs_sync  <= {vs_sync[0],  rpi_v_sync};
         col_sync <= {col_sync[0], rpi_color};
         rec_sync <= {rec_sync[0], rec};
         clk_d    <= clk_sync[1];
         vs_d     <= vs_sync[1];
      end
   end

   assign hs_s    = hs_sync[1];
   assign vs_s    = vs_sync[1];
   assign col_s   = col_sync[1];
   assign rec_s   = rec_sync[1];
   assign pix_stb = clk_sync[1] & ~clk_d;
   assign vs_rise = vs_s & ~vs_d;
   assign vs_fall = ~vs_s & vs_d;

   // rec is active-low: a synced 1 halts acceptance on this very cycle.
   assign accept      = (state == S_CAPTURE) && pix_stb && !hs_s && !vs_s && !rec_s;
   assign byte_done   = accept && (pix_cnt == 3'd7);
   assign new_byte    = {shift_dat[6:0], col_s};
   assign hshake      = wr.wr_valid && wr.wr_ready;
   assign last_hs     = hshake && (wr.wr_addr == LAST_ADDR);
   assign frame_start = (state == S_WAIT_FRAME) && vs_fall && !rec_s;

   // A byte finishing as the frame's last byte is accepted has nowhere to go; it is discarded quietly.
   assign load = byte_done && (!wr.wr_valid || hshake) && !last_hs;
   assign drop = byte_done && wr.wr_valid && !hshake;

   always_ff @(posedge FPGA_clk) begin
      if (rst) begin
         shift_dat <= '0;
         pix_cnt   <= '0;
      end else if (frame_start || ((state == S_CAPTURE) && vs_rise)) begin
         shift_dat <= '0;
         pix_cnt   <= '0;
      end else if (accept) begin
         shift_dat <= new_byte;
         pix_cnt   <= pix_cnt + 3'd1;
      end
   end

   always_ff @(posedge FPGA_clk) begin
      if (rst) begin
         wr.wr_addr  <= '0;
         wr.wr_data  <= '0;
         wr.wr_valid <= 1'b0;
         overflow    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= fd_nxt;
         if (drop) begin
            overflow <= 1'b1;
         end
         if (load) begin
            wr.wr_data  <= new_byte;
            wr.wr_valid <= 1'b1;
         end else if (hshake) begin
            wr.wr_valid <= 1'b0;
         end
         if (frame_start) begin
            wr.wr_addr <= '0;
         end else if (hshake && (wr.wr_addr != LAST_ADDR)) begin
            wr.wr_addr <= wr.wr_addr + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge FPGA_clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fd_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rec_s) begin
               state_nxt = S_WAIT_FRAME;
            end
         end
         S_WAIT_FRAME: begin
            if (rec_s) begin
               state_nxt = S_DRAIN;
            end else if (vs_fall) begin
               state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (vs_rise) begin
               fd_nxt    = 1'b1;
               state_nxt = rec_s ? S_DRAIN : S_WAIT_FRAME;
            end else if (rec_s) begin
               state_nxt = S_DRAIN;
            end else if (last_hs) begin
               state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (vs_rise) begin
               fd_nxt    = 1'b1;
               state_nxt = rec_s ? S_DRAIN : S_WAIT_FRAME;
            end
         end
         // Let a pending byte finish its handshake before going idle.
         S_DRAIN: begin
            if (!wr.wr_valid || hshake) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign full = (state == S_FULL);
endmodule

// File: tb/tb_rpi_pixel_packer.sv
// Frame-level bench: drives slow RPi pixel streams and checks every SRAM byte against a queue of packed expectations.
module tb_rpi_pixel_packer;
   localparam int AW   = 17;
   localparam int MAXB = 4;

   logic FPGA_clk   = 1'b0;
   logic rst        = 1'b1;
   logic rpi_clk    = 1'b0;
   logic rpi_h_sync = 1'b0;
   logic rpi_v_sync = 1'b1;
   logic rpi_color  = 1'b0;
   logic rec        = 1'b0;
   logic frame_done, overflow, full;

   rpi_pixel_packer_if #(.ADDR_W(AW)) wr_if ();

   rpi_pixel_packer #(.ADDR_W(AW), .MAX_BYTES(MAXB)) dut (
      .FPGA_clk   (FPGA_clk),
      .rst        (rst),
      .rpi_clk    (rpi_clk),
      .rpi_h_sync (rpi_h_sync),
      .rpi_v_sync (rpi_v_sync),
      .rpi_color  (rpi_color),
      .rec        (rec),
      .wr         (wr_if),
      .frame_done (frame_done),
      .overflow   (overflow),
      .full       (full)
   );

   always #5 FPGA_clk = ~FPGA_clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    dat;
   } exp_t;

   exp_t          exp_q[$];
   logic [7:0]    obs_dat[$];
   logic [AW-1:0] obs_addr[$];
   int            total = 0;
   int            bad = 0;
   int            rdy_mode = 1;
   int            fd_cnt = 0;
   bit            in_frame = 1'b0;
   bit            exp_ovf = 1'b0;
   int            fbytes = 0;
   int            pcnt = 0;
   logic [7:0]    acc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge FPGA_clk);
      #1;
   endtask

   // Output monitor: every accepted byte must be the next expected one; held bytes must not move.
   logic          prev_hold = 1'b0;
   logic          prev_fd = 1'b0;
   logic [7:0]    prev_dat = '0;
   logic [AW-1:0] prev_addr = '0;
   exp_t          e;
   always @(negedge FPGA_clk) begin
      if (!rst) begin
         if (prev_hold) begin
            check("hold_valid", 32'(wr_if.wr_valid), 1);
            check("hold_data", 32'(wr_if.wr_data), 32'(prev_dat));
            check("hold_addr", 32'(wr_if.wr_addr), 32'(prev_addr));
         end
         if (wr_if.wr_valid && wr_if.wr_ready) begin
            obs_dat.push_back(wr_if.wr_data);
            obs_addr.push_back(wr_if.wr_addr);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: actual=0x%0h@0x%0h required=no byte", wr_if.wr_data, wr_if.wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("byte_data", 32'(wr_if.wr_data), 32'(e.dat));
               check("byte_addr", 32'(wr_if.wr_addr), 32'(e.addr));
            end
         end
         if (frame_done) begin
            check("frame_done_width", 32'(prev_fd), 0);
            fd_cnt++;
         end
      end
      prev_hold = !rst && wr_if.wr_valid && !wr_if.wr_ready;
      prev_dat  = wr_if.wr_data;
      prev_addr = wr_if.wr_addr;
      prev_fd   = !rst && frame_done;
   end

   initial begin
      wr_if.wr_ready = 1'b0;
      forever begin
         @(posedge FPGA_clk);
         #1;
         case (rdy_mode)
            0:       wr_if.wr_ready = 1'b0;
            1:       wr_if.wr_ready = 1'b1;
            default: wr_if.wr_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Model: pixels seen with h_sync low in an active frame pack MSB-first; bytes past MAXB are never written.
   task automatic model_pixel(input logic col);
      if (fbytes >= MAXB) return;
      acc = {acc[6:0], col};
      pcnt++;
      if (pcnt == 8) begin
         pcnt = 0;
         if (rdy_mode == 0 && exp_q.size() != 0) begin
            exp_ovf = 1'b1;
         end else begin
            exp_q.push_back('{addr: AW'(fbytes), dat: acc});
            fbytes++;
         end
      end
   endtask

   task automatic rpi_pix(input logic col, input logic hs);
      rpi_color  = col;
      rpi_h_sync = hs;
      cyc(8);
      rpi_clk = 1'b1;
      if (!hs && in_frame) model_pixel(col);
      cyc(8);
      rpi_clk = 1'b0;
   endtask

   task automatic frame_begin();
      rpi_v_sync = 1'b1;
      cyc(12);
      rpi_v_sync = 1'b0;
      in_frame = (rec == 1'b0);
      fbytes = 0;
      pcnt = 0;
      acc = '0;
      obs_dat.delete();
      obs_addr.delete();
      cyc(12);
   endtask

   task automatic frame_end();
      int fd_before;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1);
      check("drain", exp_q.size(), 0);
      cyc(4);
      if (in_frame) check("addr_end", 32'(wr_if.wr_addr), (fbytes >= MAXB) ? MAXB - 1 : fbytes);
      check("full_end", 32'(full), (in_frame && fbytes >= MAXB) ? 1 : 0);
      check("overflow", 32'(overflow), 32'(exp_ovf));
      fd_before = fd_cnt;
      rpi_v_sync = 1'b1;
      cyc(10);
      check("frame_done", fd_cnt - fd_before, in_frame ? 1 : 0);
      check("full_after", 32'(full), 0);
      in_frame = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(wr_if.wr_valid), 0);
      check({tag, "_addr"}, 32'(wr_if.wr_addr), 0);
      check({tag, "_data"}, 32'(wr_if.wr_data), 0);
      check({tag, "_fdone"}, 32'(frame_done), 0);
      check({tag, "_ovf"}, 32'(overflow), 0);
      check({tag, "_full"}, 32'(full), 0);
   endtask

   initial begin
      logic [7:0] bits;
      int n;

      cyc(3);
      @(negedge FPGA_clk);
      check_zero("reset");
      cyc(1);
      rst = 1'b0;
      @(negedge FPGA_clk);
      check_zero("post_reset");
      cyc(4);

      // Alternating colour: two 0xAA bytes at 0 and 1.
      rdy_mode = 1;
      frame_begin();
      for (int i = 0; i < 16; i++) rpi_pix((i % 2) == 0, 1'b0);
      frame_end();
      check("s1_count", obs_dat.size(), 2);
      if (obs_dat.size() >= 2) begin
         check("s1_dat0", 32'(obs_dat[0]), 32'h000000AA);
         check("s1_dat1", 32'(obs_dat[1]), 32'h000000AA);
         check("s1_addr1", 32'(obs_addr[1]), 1);
      end

      // Pixels during h_sync are ignored.
      frame_begin();
      bits = 8'hF0;
      for (int i = 0; i < 8; i++) begin
         rpi_pix(~bits[7-i], 1'b1);
         rpi_pix(bits[7-i], 1'b0);
      end
      frame_end();
      check("s6_count", obs_dat.size(), 1);
      if (obs_dat.size() >= 1) check("s6_dat", 32'(obs_dat[0]), 32'h000000F0);

      // Fill to MAXB bytes of 0xFF; later pixels produce nothing.
      frame_begin();
      for (int i = 0; i < 48; i++) rpi_pix(1'b1, 1'b0);
      check("s3_full", 32'(full), 1);
      frame_end();
      check("s3_count", obs_dat.size(), 4);
      if (obs_dat.size() >= 4) begin
         check("s3_dat3", 32'(obs_dat[3]), 32'h000000FF);
         check("s3_addr3", 32'(obs_addr[3]), 3);
      end

      // Random frames with random backpressure.
      rdy_mode = 2;
      for (int f = 0; f < 10; f++) begin
         frame_begin();
         n = $urandom_range(44);
         for (int i = 0; i < n; i++) rpi_pix(1'($urandom_range(1)), $urandom_range(3) == 0);
         frame_end();
      end

      // Recording disabled after 5 pixels.
      rdy_mode = 1;
      frame_begin();
      for (int i = 0; i < 5; i++) rpi_pix(1'b1, 1'b0);
      rec = 1'b1;
      in_frame = 1'b0;
      cyc(10);
      check("s4_valid", 32'(wr_if.wr_valid), 0);
      check("s4_addr", 32'(wr_if.wr_addr), 0);
      check("s4_full", 32'(full), 0);
      for (int i = 0; i < 3; i++) rpi_pix(1'b1, 1'b0);
      frame_end();
      rec = 1'b0;
      cyc(10);

      // Backpressure: first byte held, second dropped.
      rdy_mode = 0;
      frame_begin();
      bits = 8'hCC;
      for (int i = 0; i < 8; i++) rpi_pix(bits[7-i], 1'b0);
      bits = 8'h0F;
      for (int i = 0; i < 8; i++) rpi_pix(bits[7-i], 1'b0);
      cyc(10);
      check("s2_ovf", 32'(overflow), 1);
      check("s2_valid", 32'(wr_if.wr_valid), 1);
      check("s2_dat", 32'(wr_if.wr_data), 32'h000000CC);
      check("s2_addr", 32'(wr_if.wr_addr), 0);
      rdy_mode = 1;
      frame_end();
      check("s2_count", obs_dat.size(), 1);

      // Reset with a byte pending: byte vanishes, overflow clears.
      rdy_mode = 0;
      frame_begin();
      for (int i = 0; i < 8; i++) rpi_pix(1'($urandom_range(1)), 1'b0);
      for (int i = 0; i < 200 && !wr_if.wr_valid; i++) cyc(1);
      check("s5_pending", 32'(wr_if.wr_valid), 1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      exp_q.delete();
      in_frame = 1'b0;
      exp_ovf = 1'b0;
      @(negedge FPGA_clk);
      check_zero("s5");
      rdy_mode = 1;
      cyc(60);
      frame_end();

      // Recovery frame.
      rdy_mode = 2;
      frame_begin();
      for (int i = 0; i < 20; i++) rpi_pix(1'($urandom_range(1)), 1'b0);
      frame_end();
      check("final_count", obs_dat.size(), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
